// File: rtl/dcache_assoc_pkg.sv
// Shared types and geometry helpers for the set-associative data cache.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package dcache_assoc_pkg;

  // Miss-handling controller states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  // Geometry helpers; the cache derives its own widths from these so that
  // any legal parameter set stays consistent with the defaults below.
  function automatic int offset_w_f(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int index_w_f(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int word_sel_w_f(input int line_w);
    return offset_w_f(line_w) - 2;
  endfunction

  function automatic int tag_w_f(input int addr_w, input int sets, input int line_w);
    return addr_w - offset_w_f(line_w) - index_w_f(sets);
  endfunction

  // Widths of the default geometry (32-bit address, 16 sets, 256-bit lines).
  localparam int OFFSET_W   = offset_w_f(256);
  localparam int INDEX_W    = index_w_f(16);
  localparam int TAG_W      = tag_w_f(32, 16, 256);
  localparam int WORD_SEL_W = word_sel_w_f(256);

endpackage

// File: rtl/dcache_way_array.sv
// One cache way: per-set valid, dirty, tag and line storage with async read.
// Latency: reads combinational at index; writes take effect at the clock edge.
// Backpressure: none; the controller sequences fills and word writes.
//
// Ports: clk/rst (sync, active-high; clears valid and dirty only),
//   index selects the set for both read and write, word_we writes one word
//   and marks dirty, fill_we loads a clean valid line with a new tag.
module dcache_way_array #(
  parameter int SETS       = 16,
  parameter int INDEX_W    = 4,
  parameter int TAG_W      = 23,
  parameter int LINE_W     = 256,
  parameter int DATA_W     = 32,
  parameter int WORD_SEL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_W-1:0]    index,
  output logic                  valid,
  output logic                  dirty,
  output logic [TAG_W-1:0]      tag,
  output logic [LINE_W-1:0]     line,
  input  logic                  word_we,
  input  logic [WORD_SEL_W-1:0] word_sel,
  input  logic [DATA_W-1:0]     word_dat,
  input  logic                  fill_we,
  input  logic [TAG_W-1:0]      fill_tag,
  input  logic [LINE_W-1:0]     fill_line
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] line_q [SETS];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (word_we) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tag and line payload are deliberately not reset; valid guards them.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[index]  <= fill_tag;
      line_q[index] <= fill_line;
    end else if (word_we) begin
      line_q[index][word_sel*DATA_W +: DATA_W] <= word_dat;
    end
  end

  assign valid = valid_q[index];
  assign dirty = dirty_q[index];
  assign tag   = tag_q[index];
  assign line  = line_q[index];

endmodule

// File: rtl/dcache_assoc.sv
// Write-back, write-allocate set-associative data cache with true-LRU victims.
// Latency: hits return load data combinationally; misses stall through
//   optional writeback, refill and one DONE cycle. Backpressure: p1_stall_o
//   freezes the CPU; the memory side holds its request until mem_ack_i.
//
// Ports: p1_* CPU side (word-aligned address, load/store strobes, load data,
//   stall), mem_* line-wide memory side (enable/write/address/data, ack
//   pulse), hit_cnt_o/miss_cnt_o wrapping access statistics.
module dcache_assoc
  import dcache_assoc_pkg::*;
#(
  parameter int WAYS   = 2,
  parameter int SETS   = 16,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int OFF_W  = offset_w_f(LINE_W);
  localparam int IDX_W  = index_w_f(SETS);
  localparam int TAG_BW = tag_w_f(ADDR_W, SETS, LINE_W);
  localparam int WSEL_W = word_sel_w_f(LINE_W);
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Address split.
  logic [TAG_BW-1:0] req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WSEL_W-1:0] req_wsel;
  logic              unused_addr_lsb;

  assign req_tag         = p1_addr_i[ADDR_W-1 -: TAG_BW];
  assign req_idx         = p1_addr_i[OFF_W +: IDX_W];
  assign req_wsel        = p1_addr_i[2 +: WSEL_W];
  assign unused_addr_lsb = ^p1_addr_i[1:0];

  logic req;
  assign req = p1_MemRead_i | p1_MemWrite_i;

  state_e state_q, state_d;
  logic [WAY_W-1:0] victim_q, victim_c, hit_way, lru_way;
  logic [31:0]      hit_cnt_q, miss_cnt_q;

  logic              way_valid [WAYS];
  logic              way_dirty [WAYS];
  logic [TAG_BW-1:0] way_tag   [WAYS];
  logic [LINE_W-1:0] way_line  [WAYS];
  logic [WAYS-1:0]   hit_vec, word_we, fill_we;
  logic              hit_any, lookup, access_hit;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign hit_vec[g] = way_valid[g] && (way_tag[g] == req_tag);
    assign word_we[g] = access_hit && p1_MemWrite_i && hit_vec[g];
    assign fill_we[g] = !rst_i && (state_q == ST_REFILL) && mem_ack_i &&
                        (victim_q == WAY_W'(g));

    dcache_way_array #(
      .SETS       (SETS),
      .INDEX_W    (IDX_W),
      .TAG_W      (TAG_BW),
      .LINE_W     (LINE_W),
      .DATA_W     (DATA_W),
      .WORD_SEL_W (WSEL_W)
    ) u_way (
      .clk       (clk_i),
      .rst       (rst_i),
      .index     (req_idx),
      .valid     (way_valid[g]),
      .dirty     (way_dirty[g]),
      .tag       (way_tag[g]),
      .line      (way_line[g]),
      .word_we   (word_we[g]),
      .word_sel  (req_wsel),
      .word_dat  (p1_data_i),
      .fill_we   (fill_we[g]),
      .fill_tag  (req_tag),
      .fill_line (mem_data_i)
    );
  end

  // Hit detection; IDLE and DONE are the only states that complete accesses.
  assign hit_any    = |hit_vec;
  assign lookup     = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign access_hit = !rst_i && req && lookup && hit_any;

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  // Lowest-numbered invalid way wins; otherwise the LRU way.
  always_comb begin
    victim_c = lru_way;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) victim_c = WAY_W'(w);
    end
  end

  // Per-set ages: 0 is most recent. Ages start at zero, so an invalid way can
  // share an age with the accessed one; those ages move up too (saturating),
  // which keeps every invalid way older than every valid way and the valid
  // ways a strict recency order. Once a set is full the oldest has WAYS-1.
  if (WAYS > 1) begin : g_lru
    logic [WAY_W-1:0] age_q [SETS][WAYS];
    logic [WAY_W-1:0] hit_age;

    assign hit_age = age_q[req_idx][hit_way];

    always_comb begin
      lru_way = '0;
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[req_idx][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int s = 0; s < SETS; s++) begin
          for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
        end
      end else if (access_hit) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == hit_way) begin
            age_q[req_idx][w] <= '0;
          end else if ((age_q[req_idx][w] <= hit_age) &&
                       (age_q[req_idx][w] != WAY_W'(WAYS - 1))) begin
            age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
          end
        end
      end
    end
  end else begin : g_no_lru
    assign lru_way = '0;
  end

  // Controller next state and memory/CPU handshake outputs.
  always_comb begin
    state_d      = state_q;
    p1_stall_o   = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state_q)
      ST_IDLE: begin
        if (req && !hit_any) begin
          p1_stall_o = 1'b1;
          state_d = (way_valid[victim_c] && way_dirty[victim_c]) ? ST_WRITEBACK
                                                                  : ST_REFILL;
        end
      end
      ST_WRITEBACK: begin
        p1_stall_o   = req;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {way_tag[victim_q], req_idx, {OFF_W{1'b0}}};
        mem_data_o   = way_line[victim_q];
        if (mem_ack_i) state_d = ST_REFILL;
      end
      ST_REFILL: begin
        p1_stall_o   = req;
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, req_idx, {OFF_W{1'b0}}};
        if (mem_ack_i) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst_i) begin
      state_d      = ST_IDLE;
      p1_stall_o   = 1'b0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
    end
  end

  logic [LINE_W-1:0] hit_line;
  assign hit_line  = way_line[hit_way];
  assign p1_data_o = (access_hit && p1_MemRead_i) ? hit_line[req_wsel*DATA_W +: DATA_W]
                                                  : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      victim_q   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req && !hit_any) begin
        victim_q   <= victim_c;
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
      if (state_q == ST_IDLE && access_hit) hit_cnt_q <= hit_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: doc/dcache_assoc.md
DCACHE_ASSOC -- requirements
Module: dcache_assoc

Interface
REQ-001 Parameter WAYS, default 2, associativity; legal values 1, 2, 4.
REQ-002 Parameter SETS, default 16, number of sets; power of two.
REQ-003 Parameter LINE_W, default 256, line width in bits; power of two, at least 64.
REQ-004 Parameter ADDR_W, default 32, byte address width.
REQ-005 Parameter DATA_W, default 32, CPU word width.
REQ-006 clk_i  in  1  single clock; everything SHALL be sampled on its rising edge.
REQ-007 rst_i  in  1  reset; synchronous, active-high.
REQ-008 p1_addr_i  in  ADDR_W  CPU byte address; word-aligned.
REQ-009 p1_data_i  in  DATA_W  CPU store data.
REQ-010 p1_MemRead_i  in  1  load request.
REQ-011 p1_MemWrite_i  in  1  store request; never asserted together with p1_MemRead_i.
REQ-012 p1_data_o  out  DATA_W  load data.
REQ-013 p1_stall_o  out  1  CPU pipeline freeze.
REQ-014 mem_addr_o  out  ADDR_W  line-aligned memory address.
REQ-015 mem_data_o  out  LINE_W  write-back line data.
REQ-016 mem_enable_o  out  1  memory request.
REQ-017 mem_write_o  out  1  request is a write.
REQ-018 mem_data_i  in  LINE_W  refill line data.
REQ-019 mem_ack_i  in  1  one-cycle completion pulse.
REQ-020 hit_cnt_o, miss_cnt_o  out  32 each  access statistics.

Function
REQ-021 Address split SHALL be: offset = log2(LINE_W/8) low bits, word select = offset[MSB:2], index = next log2(SETS) bits, tag = remaining bits.
REQ-022 Each way/set entry SHALL hold valid, dirty, tag and line.
REQ-023 Hit SHALL mean a valid entry in the indexed set whose tag matches; at most one way matches.
REQ-024 Read hit: p1_data_o SHALL be the selected word combinationally in the same cycle, and p1_stall_o SHALL be 0.
REQ-025 Write hit: the word SHALL be written at the clock edge, the entry marked dirty, and p1_stall_o SHALL be 0.
REQ-026 Miss: p1_stall_o SHALL rise combinationally in the request cycle and hold until the cycle in which the access completes as a hit.
REQ-027 The FSM SHALL have states IDLE, WRITEBACK, REFILL and DONE.
REQ-028 IDLE to WRITEBACK on a miss whose victim entry is valid and dirty.
REQ-029 IDLE to REFILL on a miss whose victim entry is clean or invalid.
REQ-030 WRITEBACK to REFILL on mem_ack_i; REFILL to DONE on mem_ack_i; DONE to IDLE unconditionally.
REQ-031 In WRITEBACK, the memory port SHALL drive mem_enable_o=1, mem_write_o=1, mem_addr_o = {victim tag, index, 0s} and mem_data_o = victim line.
REQ-032 In REFILL, the memory port SHALL drive mem_enable_o=1, mem_write_o=0 and mem_addr_o = {request tag, index, 0s}.
REQ-033 Memory outputs SHALL be held stable until mem_ack_i; mem_enable_o SHALL be 0 in IDLE and DONE.
REQ-034 On the REFILL ack, the victim entry SHALL be loaded with valid=1, dirty=0 and the request tag.
REQ-035 In DONE the request SHALL be re-evaluated as a hit: a store sets dirty, a load returns data, and stall drops.
REQ-036 Victim selection SHALL prefer the lowest-numbered invalid way; otherwise the true-LRU way. Each set keeps a log2(WAYS)-bit age per way.
REQ-037 LRU SHALL be updated on every hit, including the DONE hit: the accessed way becomes age 0, and ways younger than it age by 1.
REQ-038 When WAYS=1, LRU state SHALL be absent and the victim SHALL always be way 0.
REQ-039 hit_cnt_o SHALL increment once per access completing in IDLE.
REQ-040 miss_cnt_o SHALL increment once per miss at the IDLE exit; the DONE hit SHALL NOT count as a hit.
REQ-041 Both counters SHALL wrap at 2^32.
REQ-042 mem_ack_i in IDLE or DONE SHALL be ignored.
REQ-043 When no request is present, p1_stall_o SHALL be 0 and p1_data_o SHALL be 0.

Reset
REQ-044 rst_i high at a clock edge SHALL clear all valid, dirty and LRU state, clear both counters, and force the FSM to IDLE, including mid-WRITEBACK or mid-REFILL; an in-flight memory transaction is abandoned.
REQ-045 While rst_i is high, p1_stall_o, mem_enable_o and mem_write_o SHALL be 0; line data SHALL NOT be reset.

Structure
REQ-046 A shared package SHALL hold the FSM state enum and the derived widths OFFSET_W, INDEX_W, TAG_W and WORD_SEL_W.
REQ-047 Tag, valid, dirty and line storage SHALL live in one sub-module dcache_way_array, instantiated WAYS times.

Verification
REQ-048 Defaults; after reset, load 0x0000_0040 -> stall; REFILL with mem_addr_o=0x40; after ack, DONE returns word 0 of the line; miss_cnt_o=1.
REQ-049 Load 0x44 after REQ-048 -> stall=0 the same cycle, word 1 returned; hit_cnt_o=1.
REQ-050 Store 0xDEADBEEF to 0x40, fill 0x240, then load 0x440 (all set 2) -> 0x40 is the LRU victim; WRITEBACK at 0x40 with that word at line bits [31:0], then REFILL at 0x440.
REQ-051 Reset asserted in the cycle after REFILL entry -> IDLE next cycle, mem_enable_o=0, and a load to 0x40 misses again.
REQ-052 WAYS=4: fill 4 tags in set 0, re-hit tags 0, 1, 2, then miss a 5th tag -> tag 3's way is evicted.
REQ-053 A stray mem_ack_i pulse in IDLE -> no state change and no counter change.
